// File: rtl/regfile_pkg.sv
// regfile_pkg: shared scrub-state type and default register file dimensions
package regfile_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_ADDR_W = 5;
  localparam int REGFILE_NUM_RD = 2;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port with zero-register check and write bypass
module regfile_rd_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_word,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] nxt;
  // zero register wins, then same-cycle write data, then the stored word
  always_comb nxt = (ZERO_REG != 0 && rd_addr == '0) ? '0 :
                    (wr_en && wr_addr == rd_addr) ? wr_data : mem_word;
  // output register updates only when enabled after the scrub has finished
  always_ff @(posedge clk)
    if (rst) rd_data <= '0;
    else if (ready && rd_en) rd_data <= nxt;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with bypass, zero register and post-reset scrub
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int ADDR_W = REGFILE_ADDR_W,
  parameter int NUM_RD = REGFILE_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data
);
  localparam int DEPTH = 2 ** ADDR_W;
  state_t state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic ready;
  assign ready = state == READY;
  // scrub walks every entry once; all-ones pointer marks the last entry
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR;
      clr_ptr <= '0;
      busy <= 1'b1;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (&clr_ptr) begin
        state <= READY;
        busy <= 1'b0;
      end
    end
  // array is cleared by the scrub, otherwise written by the writeback port
  always_ff @(posedge clk)
    if (!rst) begin
      if (state == CLEAR) mem[clr_ptr] <= '0;
      else if (wr_en && !(ZERO_REG != 0 && wr_addr == '0)) mem[wr_addr] <= wr_data;
    end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rd (
      .clk(clk),
      .rst(rst),
      .ready(ready),
      .rd_en(rd_en[i]),
      .rd_addr(rd_addr[i*ADDR_W +: ADDR_W]),
      .mem_word(mem[rd_addr[i*ADDR_W +: ADDR_W]]),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_data(rd_data[i*DATA_W +: DATA_W])
    );
  end
endmodule
